// File: rtl/note_player_pkg.sv
// Shared state encodings and widths for the parametrised note player.
package note_player_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/half_period_timer.sv
// Loadable down-counter for one half-period; parks at zero until reloaded.
module half_period_timer #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] in,
  output logic                zero
);

  logic [PERIOD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = in;
    end else if (count_q != '0) begin
      count_d = count_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/note_player_param.sv
// Square-wave note player: N full periods of 2*(P+1) cycles, then a done pulse.
// state | meaning
// IDLE  | waiting for start, note low
// HIGH  | first half of a period, note = ~rest
// LOW   | second half of a period, repeat count decremented at its end
// DONE  | one-cycle completion pulse
module note_player_param
  import note_player_pkg::*;
#(
  parameter int PERIOD_W = 8,
  parameter int CYCLES_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CYCLES_W-1:0] cycles,
  input  logic                rest,
  output logic                busy,
  output logic                done,
  output logic [STATE_W-1:0]  state,
  output logic                note
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [CYCLES_W-1:0] rem_q, rem_d;
  logic                rest_q, rest_d;

  logic                timer_load;
  logic [PERIOD_W-1:0] timer_in;
  logic                timer_zero;

  half_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .in   (timer_in),
    .zero (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    rem_d      = rem_q;
    rest_d     = rest_q;
    timer_load = 1'b0;
    timer_in   = period_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          period_d = period;
          rest_d   = rest;
          rem_d    = cycles;
          if (cycles == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_HIGH;
            timer_load = 1'b1;
            timer_in   = period;
          end
        end
      end
      ST_HIGH: begin
        if (timer_zero) begin
          state_d    = ST_LOW;
          timer_load = 1'b1;
        end
      end
      ST_LOW: begin
        if (timer_zero) begin
          // rem only moves down from a non-zero value, so it can never wrap
          if (rem_q != '0) begin
            rem_d = rem_q - CYCLES_W'(1);
          end
          if (rem_q <= CYCLES_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_HIGH;
            timer_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stop && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      timer_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      rem_q    <= '0;
      rest_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      rem_q    <= rem_d;
      rest_q   <= rest_d;
    end
  end

  assign state = state_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign note  = (state_q == ST_HIGH) && !rest_q;

endmodule

// File: tb/tb_note_player_param.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_note_player_param;

  localparam int PERIOD_W = 8;
  localparam int CYCLES_W = 8;

  logic                clk;
  logic                rst;
  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] period;
  logic [CYCLES_W-1:0] cycles;
  logic                rest;
  logic                busy;
  logic                done;
  logic [1:0]          state;
  logic                note;

  int n_cmp;
  int n_fail;

  // model: a note is a timeline of cycles 1..total after acceptance
  bit m_active;
  int m_t;
  int m_p;
  int m_n;
  bit m_r;
  int m_total;

  note_player_param #(.PERIOD_W(PERIOD_W), .CYCLES_W(CYCLES_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .period (period),
    .cycles (cycles),
    .rest   (rest),
    .busy   (busy),
    .done   (done),
    .state  (state),
    .note   (note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {state, busy, done, note}
  function automatic logic [4:0] exp_vec();
    int ph;
    if (!m_active) return 5'b00000;
    if (m_t == m_total) return 5'b11110;
    ph = ((m_t - 1) / (m_p + 1)) % 2;
    if (ph == 0) return {2'd1, 1'b1, 1'b0, !m_r};
    return {2'd2, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (stop) m_active = 1'b0;
      else if (m_t == m_total) m_active = 1'b0;
      else m_t = m_t + 1;
    end else if (start && !stop) begin
      m_active = 1'b1;
      m_t      = 1;
      m_p      = int'(period);
      m_n      = int'(cycles);
      m_r      = rest;
      m_total  = 2 * (m_p + 1) * m_n + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; period = '0; cycles = '0; rest = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({state, busy, done, note} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset c=%0d got st=%0d busy=%b done=%b note=%b want all 0", c, state, busy, done, note);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    logic want_note;
    period = 8'd2; cycles = 8'd2; rest = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      // inputs wander while busy; the latched values must be used
      period = 8'($urandom); cycles = 8'($urandom); rest = 1'($urandom);
      want_note = (c >= 1 && c <= 3) || (c >= 7 && c <= 9);
      n_cmp++;
      if (note !== want_note || done !== (c == 13) || (c == 14 && state !== 2'd0)) begin
        n_fail++;
        $display("FAIL basic c=%0d got note=%b done=%b st=%0d want note=%b done=%b", c, note, done, state, want_note, c == 13);
      end
      n_cmp++;
      if ({state, busy, done, note} !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_model c=%0d got %b want %b", c, {state, busy, done, note}, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_fast_toggle();
    logic [5:0] pattern;
    pattern = 6'b101010;
    period = 8'd0; cycles = 8'd3; rest = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      n_cmp++;
      if ((c <= 6 && note !== pattern[6 - c]) || done !== (c == 7) || (c == 8 && busy !== 1'b0)) begin
        n_fail++;
        $display("FAIL fast c=%0d got note=%b done=%b busy=%b", c, note, done, busy);
      end
      if (c == 8) begin
        period = 8'd1; cycles = 8'd1; start = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (state !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back got st=%0d busy=%b want st=1 busy=1", state, busy);
    end
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if ({state, busy, done, note} !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back_model c=%0d got %b want %b", c, {state, busy, done, note}, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_empty();
    period = 8'd5; cycles = 8'd0; rest = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (state !== 2'd3 || done !== 1'b1 || note !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_done got st=%0d done=%b note=%b busy=%b want st=3 done=1 note=0 busy=1", state, done, note, busy);
    end
    tick();
    n_cmp++;
    if (state !== 2'd0 || done !== 1'b0 || note !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_idle got st=%0d done=%b note=%b want 0 0 0", state, done, note);
    end
  endtask

  task automatic test_rest();
    int done_at;
    done_at = -1;
    period = 8'd1; cycles = 8'd2; rest = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (done === 1'b1 && done_at < 0) done_at = c;
      n_cmp++;
      if (note !== 1'b0 || {state, busy, done, note} !== exp_vec()) begin
        n_fail++;
        $display("FAIL rest c=%0d got %b want %b", c, {state, busy, done, note}, exp_vec());
      end
      tick();
    end
    rest = 1'b0;
    n_cmp++;
    if (done_at != 9) begin
      n_fail++;
      $display("FAIL rest_done_time got %0d want 9", done_at);
    end
  endtask

  task automatic test_stop();
    period = 8'd4; cycles = 8'd3; rest = 1'b0; start = 1'b1;
    tick();
    start = 1'b1; period = 8'd0; cycles = 8'd1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (state !== 2'd1 || note !== 1'b1) begin
      n_fail++;
      $display("FAIL start_while_busy got st=%0d note=%b want st=1 note=1", state, note);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (state !== 2'd0 || note !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stop c=%0d got st=%0d note=%b done=%b busy=%b want idle", c, state, note, done, busy);
      end
      tick();
    end
    start = 1'b1; stop = 1'b1; period = 8'd4; cycles = 8'd3;
    tick();
    start = 1'b0; stop = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_beats_start got st=%0d busy=%b want 0 0", state, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    n_cmp++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_reset_low got st=%0d want 2", state);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({state, busy, done, note} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid_low got %b want 00000", {state, busy, done, note});
    end
  endtask

  task automatic test_max_period();
    int done_at;
    done_at = -1;
    period = 8'd255; cycles = 8'd1; rest = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 515; c++) begin
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (c == 1 || c == 256 || c == 257 || c == 512 || c == 513 || c == 514) begin
        n_cmp++;
        if ({state, busy, done, note} !== exp_vec()) begin
          n_fail++;
          $display("FAIL max_period c=%0d got %b want %b", c, {state, busy, done, note}, exp_vec());
        end
      end
      tick();
    end
    n_cmp++;
    if (done_at != 513) begin
      n_fail++;
      $display("FAIL max_period_done got %0d want 513", done_at);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom_range(0, 2) == 0);
      stop   = ($urandom_range(0, 59) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      period = 8'($urandom_range(0, 6));
      cycles = 8'($urandom_range(0, 4));
      rest   = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if ({state, busy, done, note} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c=%0d got %b want %b", c, {state, busy, done, note}, exp_vec());
      end
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_active = 1'b0;
    m_t = 0; m_p = 0; m_n = 0; m_r = 1'b0; m_total = 1;
    rst = 1'b1; start = 1'b0; stop = 1'b0; period = '0; cycles = '0; rest = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_fast_toggle();
    test_empty();
    test_rest();
    test_stop();
    test_max_period();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
